// File: rtl/tx_interrupt_gen_pkg.sv
// Shared definitions for the TX interrupt coalescer: counter width and one-hot FSM encodings.
package tx_interrupt_gen_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ACCUM   = 4'b0010,
    S_REQ     = 4'b0100,
    S_HOLDOFF = 4'b1000
  } state_t;

endpackage

// File: rtl/tx_interrupt_gen_if.sv
// Bundle of TX-completion, configuration and PCIe cfg-interrupt signals around the coalescer.
interface tx_interrupt_gen_if #(
  parameter int CNT_W = tx_interrupt_gen_pkg::CNT_W
);
  import tx_interrupt_gen_pkg::*;

  // Request/accept: cfg_interrupt_n low is the request, cfg_interrupt_rdy_n low is the accept;
  // the transfer happens on the rising edge where both are low, and a request is never withdrawn.
  logic             cfg_interrupt_n;
  logic             cfg_interrupt_rdy_n;
  logic             tx_done;
  logic             interrupts_enabled;
  logic [CNT_W-1:0] coalesce_threshold;
  logic [31:0]      coalesce_timeout;
  logic [31:0]      interrupt_period;
  logic [CNT_W-1:0] pending_count;
  logic [31:0]      irq_count;
  state_t           state;

  modport slave (
    input  cfg_interrupt_rdy_n, tx_done, interrupts_enabled,
    input  coalesce_threshold, coalesce_timeout, interrupt_period,
    output cfg_interrupt_n, pending_count, irq_count, state
  );

  modport master (
    output cfg_interrupt_rdy_n, tx_done, interrupts_enabled,
    output coalesce_threshold, coalesce_timeout, interrupt_period,
    input  cfg_interrupt_n, pending_count, irq_count, state
  );

endinterface

// File: rtl/tx_interrupt_gen_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear beats load beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tx_interrupt_gen.sv
// Coalesces TX completions into MSI requests on threshold or timeout, with a hold-off after each.
module tx_interrupt_gen #(
  parameter int CNT_W = tx_interrupt_gen_pkg::CNT_W
) (
  input logic              clk,
  input logic              reset,
  tx_interrupt_gen_if.slave bus
);
  import tx_interrupt_gen_pkg::*;

  state_t           state_q;
  logic             cfg_n_q;
  logic [31:0]      irq_q;
  logic [31:0]      hold_q;
  logic [CNT_W-1:0] thr_q;
  logic [31:0]      tmo_q;
  logic [31:0]      per_q;

  logic [CNT_W-1:0] pend;
  logic [31:0]      timer;
  logic [CNT_W-1:0] thr_eff;
  logic             handshake;
  logic             hold_done;
  logic             resume_accum;
  logic             timer_clr;
  logic             fire;

  assign handshake = !cfg_n_q && !bus.cfg_interrupt_rdy_n;
  assign hold_done = (state_q == S_HOLDOFF) && (hold_q == per_q);
  // A completion landing on the hold-off exit cycle must not strand a non-zero count in S_IDLE.
  assign resume_accum = (pend != '0) || bus.tx_done;
  assign timer_clr = ((state_q == S_IDLE) && bus.tx_done) || (hold_done && resume_accum);
  assign thr_eff = (thr_q == '0) ? CNT_W'(1) : thr_q;
  assign fire = (pend >= thr_eff) || (timer >= tmo_q);

  sat_counter #(.W(CNT_W)) u_pending (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (1'b0),
    .load_i     (handshake),
    .load_val_i (CNT_W'(bus.tx_done)),
    .inc_i      (bus.tx_done),
    .cnt_o      (pend)
  );

  sat_counter #(.W(32)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (timer_clr),
    .load_i     (1'b0),
    .load_val_i (32'd0),
    .inc_i      (state_q == S_ACCUM),
    .cnt_o      (timer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cfg_n_q <= 1'b1;
      irq_q   <= '0;
      hold_q  <= '0;
      thr_q   <= '0;
      tmo_q   <= '0;
      per_q   <= '0;
    end else begin
      thr_q <= bus.coalesce_threshold;
      tmo_q <= bus.coalesce_timeout;
      per_q <= bus.interrupt_period;
      case (state_q)
        S_IDLE: begin
          if (bus.tx_done) state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (fire && bus.interrupts_enabled) begin
            state_q <= S_REQ;
            cfg_n_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (handshake) begin
            state_q <= S_HOLDOFF;
            cfg_n_q <= 1'b1;
            irq_q   <= irq_q + 32'd1;
            hold_q  <= '0;
          end
        end
        S_HOLDOFF: begin
          if (hold_done) begin
            state_q <= resume_accum ? S_ACCUM : S_IDLE;
          end else begin
            hold_q <= hold_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cfg_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cfg_interrupt_n = cfg_n_q;
  assign bus.pending_count   = pend;
  assign bus.irq_count       = irq_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_tx_interrupt_gen.sv
// Directed bench for tx_interrupt_gen: cycle table for the threshold path, hand sequences for the rest.
module tb_tx_interrupt_gen;
  import tx_interrupt_gen_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  logic [31:0] exp_q[$];

  tx_interrupt_gen_if #(.CNT_W(16)) bus ();

  tx_interrupt_gen #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        td;
    logic        rdy_n;
    logic        en;
    logic        cfg_n;
    logic [15:0] pend;
    logic [31:0] irq;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[$];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic td, input logic rdy_n, input logic en);
    bus.tx_done             = td;
    bus.cfg_interrupt_rdy_n = rdy_n;
    bus.interrupts_enabled  = en;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] thr, input logic [31:0] tmo, input logic [31:0] per);
    bus.coalesce_threshold = thr;
    bus.coalesce_timeout   = tmo;
    bus.interrupt_period   = per;
  endtask

  // Scoreboard: each accepted interrupt consumes the next expected irq_count.
  task automatic check_accept(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, bus.irq_count, e);
    end
  endtask

  function automatic void add(input logic td, input logic rdy_n, input logic cfg_n,
                              input logic [15:0] pend, input logic [31:0] irq, input state_t st);
    vec_t v;
    v.td = td; v.rdy_n = rdy_n; v.en = 1'b1;
    v.cfg_n = cfg_n; v.pend = pend; v.irq = irq; v.st = st;
    tbl.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    int lows;
    int highs;
    bit seen;

    n_checks = 0;
    n_err    = 0;
    exp_q    = '{32'd2, 32'd3, 32'd4};

    // Threshold 4: four back-to-back completions, accept three cycles into the request, hold-off 11 cycles.
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, 16'(i + 1), 32'd0, S_ACCUM);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 16'd4, 32'd0, S_REQ);
    add(1'b0, 1'b0, 1'b1, 16'd0, 32'd1, S_HOLDOFF);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 1'b1, 16'd0, 32'd1, S_HOLDOFF);
    add(1'b0, 1'b1, 1'b1, 16'd0, 32'd1, S_IDLE);

    // ---- reset ----
    reset = 1'b1;
    set_cfg(16'd4, 32'd1000, 32'd10);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("reset_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    check("reset_pending", 32'(bus.pending_count), 32'd0);
    check("reset_irq", bus.irq_count, 32'd0);
    check("reset_state", 32'(bus.state), 32'(S_IDLE));
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].td, tbl[i].rdy_n, tbl[i].en);
      check($sformatf("tbl%0d_cfg_n", i), 32'(bus.cfg_interrupt_n), 32'(tbl[i].cfg_n));
      check($sformatf("tbl%0d_pending", i), 32'(bus.pending_count), 32'(tbl[i].pend));
      check($sformatf("tbl%0d_irq", i), bus.irq_count, tbl[i].irq);
      check($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
    end

    // ---- timeout 20 with a single completion ----
    set_cfg(16'd100, 32'd20, 32'd5);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("tmo_enter_state", 32'(bus.state), 32'(S_ACCUM));
    repeat (20) step(1'b0, 1'b1, 1'b1);
    check("tmo_early_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    step(1'b0, 1'b1, 1'b1);
    check("tmo_fire_cfg_n", 32'(bus.cfg_interrupt_n), 32'd0);
    check("tmo_fire_pending", 32'(bus.pending_count), 32'd1);

    // ---- completion on the handshake cycle, hold-off 6 cycles, second timeout ----
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("req_held_cfg_n", 32'(bus.cfg_interrupt_n), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("hs_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    check("hs_pending", 32'(bus.pending_count), 32'd1);
    check_accept("hs_irq");
    repeat (5) step(1'b0, 1'b1, 1'b1);
    check("holdoff_last_state", 32'(bus.state), 32'(S_HOLDOFF));
    step(1'b0, 1'b1, 1'b1);
    check("holdoff_exit_state", 32'(bus.state), 32'(S_ACCUM));
    repeat (20) step(1'b0, 1'b1, 1'b1);
    check("tmo2_early_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    step(1'b0, 1'b1, 1'b1);
    check("tmo2_fire_cfg_n", 32'(bus.cfg_interrupt_n), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check_accept("tmo2_irq");
    check("tmo2_pending", 32'(bus.pending_count), 32'd0);
    repeat (6) step(1'b0, 1'b1, 1'b1);
    check("back_to_idle", 32'(bus.state), 32'(S_IDLE));

    // ---- threshold 0 behaves as 1 ----
    set_cfg(16'd0, 32'd1000, 32'd5);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (bus.cfg_interrupt_n == 1'b0) seen = 1'b1;
    end
    check("thr0_request_seen", 32'(seen), 32'd1);
    check("thr0_pending", 32'(bus.pending_count), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check_accept("thr0_irq");
    repeat (6) step(1'b0, 1'b1, 1'b1);
    check("thr0_idle", 32'(bus.state), 32'(S_IDLE));

    // ---- interrupts disabled: 50 completions then enable ----
    set_cfg(16'd100, 32'd20, 32'd5);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    lows = 0;
    repeat (50) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus.cfg_interrupt_n == 1'b0) lows++;
    end
    repeat (30) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.cfg_interrupt_n == 1'b0) lows++;
    end
    check("dis_no_request", 32'(lows), 32'd0);
    check("dis_pending", 32'(bus.pending_count), 32'd50);
    check("dis_state", 32'(bus.state), 32'(S_ACCUM));
    step(1'b0, 1'b1, 1'b1);
    check("en_request_cfg_n", 32'(bus.cfg_interrupt_n), 32'd0);
    check("en_request_state", 32'(bus.state), 32'(S_REQ));

    // ---- request held while enable toggles; pending saturates ----
    highs = 0;
    repeat (70000) begin
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      if (bus.cfg_interrupt_n != 1'b0) highs++;
    end
    check("hold_req_no_release", 32'(highs), 32'd0);
    check("sat_pending", 32'(bus.pending_count), 32'd65535);
    check("sat_irq", bus.irq_count, 32'd4);

    // ---- reset during S_REQ ----
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    check("rst_req_cfg_n", 32'(bus.cfg_interrupt_n), 32'd1);
    check("rst_req_pending", 32'(bus.pending_count), 32'd0);
    check("rst_req_irq", bus.irq_count, 32'd0);
    check("rst_req_state", 32'(bus.state), 32'(S_IDLE));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
